branch_cond_unit: RTL and testbench
===================================

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles flush is asserted after a taken branch; legal range 1..15.
REQ-002 Reset and clock: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 flag_we  in  1  capture ALU flags this cycle.
REQ-006 zero_flag, negative_flag, carry_flag, overflow_flag  in  1 each  ALU flags (carry = borrow on SUB).
REQ-007 br_valid  in  1  branch request present.
REQ-008 br_ready  out  1  unit can accept a request.
REQ-009 br_cond  in  4  condition code.
REQ-010 br_pc  in  32  branch instruction address.
REQ-011 br_offset  in  32  signed byte offset.
REQ-012 res_valid  out  1  one-cycle result pulse.
REQ-013 res_taken  out  1  condition true.
REQ-014 res_target  out  32  br_pc + br_offset.
REQ-015 res_illegal  out  1  br_cond not a defined code.
REQ-016 flush  out  1  pipeline flush request.
REQ-017 flags_q  out  4  registered flags {Z,N,C,V}, MSB = Z.

Function
REQ-018 Flag register shall load {Z,N,C,V} on every edge with flag_we=1, in every FSM state.
REQ-019 Condition codes: 0000 EQ=Z; 0001 NE=!Z; 0010 LT=N^V; 0011 GE=!(N^V); 0100 LTU=C; 0101 GEU=!C; 0110 MI=N; 0111 PL=!N; 1000 VS=V; 1001 VC=!V; 1010 AL=1; 1011 NV=0.
REQ-020 Codes 1100..1111 shall give res_taken=0, res_illegal=1, and no flush.
REQ-021 Bypass: when flag_we=1 in the accept cycle, evaluation shall use the incoming flags, not flags_q.
REQ-022 res_target shall be the 32-bit modulo sum; carry out of bit 31 discarded (wrap-around).
REQ-023 FSM states: IDLE, RESP, FLUSH.
REQ-024 IDLE: br_ready=1; a request is accepted when br_valid and br_ready are both 1; on accept -> RESP; otherwise stay.
REQ-025 RESP: res_valid=1 for exactly one cycle with registered taken/target/illegal; br_ready=0.
REQ-026 RESP -> FLUSH if taken and FLUSH_CYCLES>1; RESP -> IDLE otherwise.
REQ-027 flush=1 for exactly FLUSH_CYCLES consecutive cycles, starting in the RESP cycle of a taken branch.
REQ-028 FLUSH: down-counter, br_ready=0; -> IDLE when the counter expires.
REQ-029 Latency: request accepted at edge N -> res_valid high in cycle N+1; minimum issue interval is 2 cycles (not-taken) or 1+FLUSH_CYCLES cycles (taken).
REQ-030 br_valid while br_ready=0 shall be ignored; the requester shall hold it.
REQ-031 res_* outputs shall hold their last value when res_valid=0.

Reset
REQ-032 rst=1 shall immediately force state=IDLE, flags_q=0, counter=0, res_valid=0, res_taken=0, res_target=0, res_illegal=0, flush=0.
REQ-033 br_ready shall be 0 while rst=1, and 1 in the first cycle after deassertion.
REQ-034 Reset mid-RESP or mid-FLUSH shall abort the operation with no residual pulse after deassertion.

Structure
REQ-035 Shared package branch_pkg shall hold the condition-code constants, the FSM state enumeration, and the FLUSH_CYCLES default.
REQ-036 Condition evaluation shall be a combinational sub-module cond_eval (inputs: flags, cond; outputs: taken, illegal).

Verification
REQ-037 flag_we with Z=1, then br_cond=0000, br_pc=0x100, br_offset=0x20 -> res_valid next cycle, res_taken=1, res_target=0x120, flush high 2 cycles, br_ready low 2 cycles.
REQ-038 flag_we with N=1, V=0 in the same cycle as accept, br_cond=0010 (LT), flags_q previously 0 -> res_taken=1 (bypass used).
REQ-039 br_pc=0xFFFF_FFF0, br_offset=0x20, br_cond=1010 -> res_target=0x0000_0010, res_taken=1.
REQ-040 br_cond=1101 -> res_illegal=1, res_taken=0, flush=0, br_ready=1 two cycles after accept.
REQ-041 rst asserted during the first flush cycle -> flush=0 and res_valid=0 immediately; br_ready=1 in the first cycle after release.
REQ-042 C=1 then back-to-back LTU requests held on br_valid -> second request accepted only after the flush window ends; both results taken.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants for the branch condition unit: condition codes, FSM states, flush default.
package branch_pkg;

    localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;

    // Flags are packed {Z, N, C, V}, Z in the MSB.
    typedef logic [3:0] flags_t;

    localparam logic [3:0] COND_EQ  = 4'b0000;
    localparam logic [3:0] COND_NE  = 4'b0001;
    localparam logic [3:0] COND_LT  = 4'b0010;
    localparam logic [3:0] COND_GE  = 4'b0011;
    localparam logic [3:0] COND_LTU = 4'b0100;
    localparam logic [3:0] COND_GEU = 4'b0101;
    localparam logic [3:0] COND_MI  = 4'b0110;
    localparam logic [3:0] COND_PL  = 4'b0111;
    localparam logic [3:0] COND_VS  = 4'b1000;
    localparam logic [3:0] COND_VC  = 4'b1001;
    localparam logic [3:0] COND_AL  = 4'b1010;
    localparam logic [3:0] COND_NV  = 4'b1011;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RESP  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluator over {Z, N, C, V} flags.
module cond_eval
    import branch_pkg::*;
(
    input  flags_t     flags,
    input  logic [3:0] cond,
    output logic       taken,
    output logic       illegal
);

    logic z, n, c, v;

    assign {z, n, c, v} = flags;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (cond)
            COND_EQ:  taken = z;
            COND_NE:  taken = ~z;
            COND_LT:  taken = n ^ v;
            COND_GE:  taken = ~(n ^ v);
            COND_LTU: taken = c;
            COND_GEU: taken = ~c;
            COND_MI:  taken = n;
            COND_PL:  taken = ~n;
            COND_VS:  taken = v;
            COND_VC:  taken = ~v;
            COND_AL:  taken = 1'b1;
            COND_NV:  taken = 1'b0;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch resolution unit: captures ALU flags, evaluates a condition per request,
// reports the result for one cycle and requests a pipeline flush on taken branches.
module branch_cond_unit
    import branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flag_we,
    input  logic        zero_flag,
    input  logic        negative_flag,
    input  logic        carry_flag,
    input  logic        overflow_flag,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [3:0]  br_cond,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset,
    output logic        res_valid,
    output logic        res_taken,
    output logic [31:0] res_target,
    output logic        res_illegal,
    output logic        flush,
    output logic [3:0]  flags_q
);

    // RESP already covers the first flush cycle, so FLUSH runs FLUSH_CYCLES-1 cycles.
    localparam logic [3:0] CNT_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    flags_t     flags_in, flags_eff;
    logic       eval_taken, eval_illegal;
    logic       accept;

    assign flags_in  = {zero_flag, negative_flag, carry_flag, overflow_flag};
    // Flags written in the accept cycle take effect for that same request.
    assign flags_eff = flag_we ? flags_in : flags_q;

    assign br_ready  = ~rst && (state_q == ST_IDLE);
    assign accept    = br_valid && br_ready;
    assign res_valid = (state_q == ST_RESP);
    assign flush     = ((state_q == ST_RESP) && res_taken) || (state_q == ST_FLUSH);

    cond_eval u_cond_eval (
        .flags   (flags_eff),
        .cond    (br_cond),
        .taken   (eval_taken),
        .illegal (eval_illegal)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (res_taken && (FLUSH_CYCLES > 1)) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'd0;
        end else if (flag_we) begin
            flags_q <= flags_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_taken   <= 1'b0;
            res_target  <= 32'd0;
            res_illegal <= 1'b0;
        end else if (accept) begin
            res_taken   <= eval_taken;
            res_target  <= br_pc + br_offset;
            res_illegal <= eval_illegal;
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Randomized and directed checks of branch_cond_unit against a cycle-indexed reference model.
module tb_branch_cond_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flag_we;
    logic        zero_flag, negative_flag, carry_flag, overflow_flag;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_cond;
    logic [31:0] br_pc, br_offset;
    logic        res_valid, res_taken, res_illegal, flush;
    logic [31:0] res_target;
    logic [3:0]  flags_q;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: absolute cycle index and the windows in which each output is expected high.
    int          cyc;
    int          ready_at, resp_cyc, flush_lo, flush_hi;
    logic [3:0]  m_flags;
    logic        m_taken, m_illegal;
    logic [31:0] m_target;

    branch_cond_unit #(
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flag_we       (flag_we),
        .zero_flag     (zero_flag),
        .negative_flag (negative_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_cond       (br_cond),
        .br_pc         (br_pc),
        .br_offset     (br_offset),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .res_illegal   (res_illegal),
        .flush         (flush),
        .flags_q       (flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    // Codes pair up as (condition, inverse); odd codes invert the even one.
    function automatic bit ref_taken(input logic [3:0] f, input logic [3:0] cc);
        bit z, n, c, v, base;
        z = f[3]; n = f[2]; c = f[1]; v = f[0];
        if (cc >= 4'd12) return 1'b0;
        case (cc[3:1])
            3'd0:    base = z;
            3'd1:    base = (n != v);
            3'd2:    base = c;
            3'd3:    base = n;
            3'd4:    base = v;
            default: base = 1'b1;
        endcase
        return cc[0] ? !base : base;
    endfunction

    function automatic bit exp_ready();
        return !rst && (cyc >= ready_at);
    endfunction

    task automatic model_reset();
        ready_at  = 0;
        resp_cyc  = -1;
        flush_lo  = 0;
        flush_hi  = 0;
        m_flags   = 4'd0;
        m_taken   = 1'b0;
        m_illegal = 1'b0;
        m_target  = 32'd0;
    endtask

    task automatic check_all();
        check("br_ready",    32'(br_ready),    32'(exp_ready()));
        check("res_valid",   32'(res_valid),   32'(!rst && cyc == resp_cyc));
        check("flush",       32'(flush),       32'(!rst && cyc >= flush_lo && cyc < flush_hi));
        check("flags_q",     32'(flags_q),     32'(m_flags));
        check("res_taken",   32'(res_taken),   32'(m_taken));
        check("res_illegal", 32'(res_illegal), 32'(m_illegal));
        check("res_target",  res_target,       m_target);
    endtask

    task automatic tick();
        logic [3:0] eff;
        bit         t;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (br_valid && exp_ready()) begin
                eff       = flag_we ? {zero_flag, negative_flag, carry_flag, overflow_flag}
                                    : m_flags;
                t         = ref_taken(eff, br_cond);
                m_taken   = t;
                m_illegal = (br_cond >= 4'd12);
                m_target  = br_pc + br_offset;
                resp_cyc  = cyc + 1;
                ready_at  = cyc + 1 + (t ? FC : 1);
                if (t) begin
                    flush_lo = cyc + 1;
                    flush_hi = cyc + 1 + FC;
                end
            end
            if (flag_we) m_flags = {zero_flag, negative_flag, carry_flag, overflow_flag};
        end
        cyc++;
        #1;
        check_all();
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
    endtask

    task automatic set_flags(input logic [3:0] f);
        flag_we = 1'b1;
        {zero_flag, negative_flag, carry_flag, overflow_flag} = f;
    endtask

    task automatic request(input logic [3:0] cc, input logic [31:0] pc, input logic [31:0] off);
        br_valid  = 1'b1;
        br_cond   = cc;
        br_pc     = pc;
        br_offset = off;
    endtask

    task automatic quiet(input int k);
        br_valid = 1'b0;
        flag_we  = 1'b0;
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        int pulses[$];

        cyc = 0;
        rst = 1'b1;
        flag_we = 1'b0;
        {zero_flag, negative_flag, carry_flag, overflow_flag} = 4'd0;
        br_valid = 1'b0; br_cond = 4'd0; br_pc = 32'd0; br_offset = 32'd0;
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(br_ready), 32'd1);

        // EQ taken with Z loaded beforehand
        set_flags(4'b1000);
        tick();
        flag_we = 1'b0;
        request(4'b0000, 32'h100, 32'h20);
        tick();
        check("eq_valid", 32'(res_valid), 32'd1);
        check("eq_taken", 32'(res_taken), 32'd1);
        check("eq_target", res_target, 32'h120);
        check("eq_flush0", 32'(flush), 32'd1);
        br_valid = 1'b0;
        tick();
        check("eq_flush1", 32'(flush), 32'd1);
        check("eq_ready1", 32'(br_ready), 32'd0);
        tick();
        check("eq_flush_end", 32'(flush), 32'd0);

        // LT with bypassed flags
        set_flags(4'b0000);
        tick();
        set_flags(4'b0100);
        request(4'b0010, 32'h2000, 32'hFFFF_FFF0);
        tick();
        check("lt_bypass_taken", 32'(res_taken), 32'd1);
        quiet(3);

        // AL with target wrap
        request(4'b1010, 32'hFFFF_FFF0, 32'h20);
        tick();
        check("wrap_target", res_target, 32'h10);
        check("wrap_taken", 32'(res_taken), 32'd1);
        quiet(3);

        // Illegal code
        request(4'b1101, 32'h40, 32'h4);
        tick();
        check("ill_illegal", 32'(res_illegal), 32'd1);
        check("ill_taken", 32'(res_taken), 32'd0);
        check("ill_flush", 32'(flush), 32'd0);
        br_valid = 1'b0;
        tick();
        check("ill_ready", 32'(br_ready), 32'd1);

        // Reset during the first flush cycle
        request(4'b1010, 32'h80, 32'h8);
        tick();
        br_valid = 1'b0;
        check("rst_pre_flush", 32'(flush), 32'd1);
        assert_reset();
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(br_ready), 32'd1);
        quiet(2);

        // Back-to-back LTU requests held on br_valid
        set_flags(4'b0010);
        tick();
        flag_we = 1'b0;
        request(4'b0100, 32'h300, 32'h10);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (res_valid) begin
                pulses.push_back(cyc);
                check("b2b_taken", 32'(res_taken), 32'd1);
                if (pulses.size() == 2) br_valid = 1'b0;
            end
        end
        check("b2b_count", 32'(pulses.size()), 32'd2);
        if (pulses.size() == 2)
            check("b2b_interval", 32'(pulses[1] - pulses[0]), 32'(1 + FC));
        br_valid = 1'b0;

        // Random traffic; requests are held until the model says they were accepted
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                assert_reset();
                tick();
                rst = 1'b0;
                #1;
                check_all();
            end
            flag_we = 1'($urandom_range(0, 1));
            {zero_flag, negative_flag, carry_flag, overflow_flag} = 4'($urandom);
            if (!br_valid || resp_cyc == cyc) begin
                br_valid  = ($urandom_range(0, 9) < 7);
                br_cond   = 4'($urandom);
                br_pc     = $urandom;
                br_offset = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255))
                                                        : 32'($urandom);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
